// File: rtl/pb_refresh_dispatcher_pkg.sv
// Purpose: shared defaults and FSM state encoding for the per-bank refresh dispatcher.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pb_refresh_pkg;

    localparam int DEF_NUM_CNT         = 4;
    localparam int DEF_NUM_BANKS       = 8;
    localparam int DEF_BANK_ADDR_WIDTH = 3;
    localparam int DEF_TRFC_PB_WIDTH   = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } disp_state_t;

endpackage

// File: rtl/pb_refresh_dispatcher_select.sv
// Purpose: pick the lowest-index set bit of a free mask as a one-hot vector.
// Latency: combinational.
// Backpressure: none; o_any_free low means nothing can be picked.
module lowest_free_select #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_free,
    output logic [N-1:0] o_onehot,
    output logic         o_any_free
);

    // Two's-complement trick isolates the least significant set bit.
    assign o_onehot   = i_free & (~i_free + N'(1));
    assign o_any_free = |i_free;

endmodule

// File: rtl/pb_refresh_dispatcher.sv
// Purpose: accept per-bank refresh requests and hand each to the lowest free tRFCpb counter, tracking busy banks.
// Latency: accept at T, counter start at T+1 at the earliest; bank_busy set at T+2; refresh_done one cycle after cnt_done.
// Backpressure: req_ready drops while a request is pending (target bank busy or no free counter); at most one request per 2 cycles.
module pb_refresh_dispatcher
    import pb_refresh_pkg::*;
#(
    parameter int NUM_CNT         = DEF_NUM_CNT,
    parameter int NUM_BANKS       = DEF_NUM_BANKS,
    parameter int BANK_ADDR_WIDTH = DEF_BANK_ADDR_WIDTH,
    parameter int TRFC_PB_WIDTH   = DEF_TRFC_PB_WIDTH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               req_valid,
    input  logic [BANK_ADDR_WIDTH-1:0]         req_bank,
    output logic                               req_ready,
    input  logic [TRFC_PB_WIDTH-1:0]           trfc_pb,
    output logic [NUM_CNT-1:0]                 cnt_start,
    output logic [BANK_ADDR_WIDTH-1:0]         cnt_bank,
    output logic [TRFC_PB_WIDTH-1:0]           cnt_trfc_pb,
    input  logic [NUM_CNT-1:0]                 cnt_assigned,
    input  logic [NUM_CNT-1:0]                 cnt_done,
    input  logic [NUM_CNT*BANK_ADDR_WIDTH-1:0] cnt_assigned_bank,
    output logic [NUM_BANKS-1:0]               bank_busy,
    output logic [NUM_BANKS-1:0]               refresh_done,
    output logic                               err
);

    disp_state_t                r_state;
    logic                       r_req_ready;
    logic [BANK_ADDR_WIDTH-1:0] r_pend_bank;
    logic [NUM_CNT-1:0]         r_reserved;
    logic [NUM_CNT-1:0]         r_assigned_q;
    logic [NUM_BANKS-1:0]       r_bank_busy;
    logic [NUM_BANKS-1:0]       r_refresh_done;
    logic                       r_err;

    logic [NUM_CNT-1:0]         w_free;
    logic [NUM_CNT-1:0]         w_pick;
    logic                       w_any_free;
    logic                       w_dispatch;
    logic                       w_accept;
    logic [NUM_BANKS-1:0]       w_busy_set;
    logic [NUM_BANKS-1:0]       w_done_mask;
    logic                       w_done_idle;
    logic                       w_done_dup;
    logic                       w_rogue_asg;
    logic [BANK_ADDR_WIDTH-1:0] w_slot_bank [NUM_CNT];

    // A counter that was just started is reserved until its assigned flag shows up.
    assign w_free = ~cnt_assigned & ~r_reserved;

    lowest_free_select #(
        .N (NUM_CNT)
    ) u_select (
        .i_free     (w_free),
        .o_onehot   (w_pick),
        .o_any_free (w_any_free)
    );

    assign w_accept   = (r_state == ST_IDLE) && req_valid;
    assign w_dispatch = (r_state == ST_PEND) && !r_bank_busy[r_pend_bank] && w_any_free;

    assign req_ready    = r_req_ready;
    assign cnt_start    = w_dispatch ? w_pick : '0;
    assign cnt_bank     = r_pend_bank;
    assign cnt_trfc_pb  = trfc_pb;
    assign bank_busy    = r_bank_busy;
    assign refresh_done = r_refresh_done;
    assign err          = r_err;

    // Unpack the per-counter bank slices and decode the dispatch target.
    always_comb begin
        w_busy_set = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            w_slot_bank[i] = cnt_assigned_bank[i*BANK_ADDR_WIDTH +: BANK_ADDR_WIDTH];
        end
        if (w_dispatch) begin
            w_busy_set[r_pend_bank] = 1'b1;
        end
    end

    // Collapse all done pulses of this cycle into one bank mask and flag inconsistent reports.
    always_comb begin
        w_done_mask = '0;
        w_done_idle = 1'b0;
        w_done_dup  = 1'b0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (cnt_done[i]) begin
                w_done_mask[w_slot_bank[i]] = 1'b1;
                if (!r_bank_busy[w_slot_bank[i]]) begin
                    w_done_idle = 1'b1;
                end
                for (int j = 0; j < i; j++) begin
                    if (cnt_done[j] && (w_slot_bank[j] == w_slot_bank[i])) begin
                        w_done_dup = 1'b1;
                    end
                end
            end
        end
    end

    assign w_rogue_asg = |(cnt_assigned & ~r_assigned_q & ~r_reserved);

    // Request FSM: IDLE takes a request, PEND holds it until it can be dispatched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
            r_pend_bank <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state     <= ST_PEND;
                        r_req_ready <= 1'b0;
                        r_pend_bank <= req_bank;
                    end
                end
                ST_PEND: begin
                    if (w_dispatch) begin
                        r_state     <= ST_IDLE;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    // Track reservations from start until assigned rises, plus last-cycle assigned for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reserved   <= '0;
            r_assigned_q <= '0;
        end else begin
            r_reserved   <= (r_reserved & ~cnt_assigned) | cnt_start;
            r_assigned_q <= cnt_assigned;
        end
    end

    // Bank busy is set one cycle after dispatch and released one cycle after its done; done mask is echoed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank_busy    <= '0;
            r_refresh_done <= '0;
        end else begin
            r_bank_busy    <= (r_bank_busy & ~w_done_mask) | w_busy_set;
            r_refresh_done <= w_done_mask;
        end
    end

    // Sticky protocol error, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_done_idle || w_done_dup || w_rogue_asg) begin
            r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pb_refresh_dispatcher.sv
// Purpose: directed self-checking bench for pb_refresh_dispatcher with a simple counter model.
// Latency: n/a.
// Backpressure: n/a.
module tb_pb_refresh_dispatcher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [2:0]  req_bank;
    logic        req_ready;
    logic [7:0]  trfc_pb;
    logic [3:0]  cnt_start;
    logic [2:0]  cnt_bank;
    logic [7:0]  cnt_trfc_pb;
    logic [3:0]  cnt_assigned;
    logic [3:0]  cnt_done;
    logic [11:0] cnt_assigned_bank;
    logic [7:0]  bank_busy;
    logic [7:0]  refresh_done;
    logic        err;

    always #5 clk = ~clk;

    pb_refresh_dispatcher dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid         (req_valid),
        .req_bank          (req_bank),
        .req_ready         (req_ready),
        .trfc_pb           (trfc_pb),
        .cnt_start         (cnt_start),
        .cnt_bank          (cnt_bank),
        .cnt_trfc_pb       (cnt_trfc_pb),
        .cnt_assigned      (cnt_assigned),
        .cnt_done          (cnt_done),
        .cnt_assigned_bank (cnt_assigned_bank),
        .bank_busy         (bank_busy),
        .refresh_done      (refresh_done),
        .err               (err)
    );

    int n_chk = 0;
    int n_err = 0;

    // counter model state
    logic [3:0] m_asg;
    logic [3:0] m_pend;
    logic [3:0] done_next;
    logic [2:0] m_bank [4];
    int         m_wait [4];
    int         asg_dly;
    int         dbl_start;
    logic       hs_seen;

    typedef struct {
        logic       rv;
        logic [2:0] rb;
        logic [3:0] fin;
        logic       x_ready;
        logic [3:0] x_start;
        logic [2:0] x_cbank;
        logic [7:0] x_busy;
        logic [7:0] x_rdone;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_model();
        cnt_assigned      = m_asg;
        cnt_assigned_bank = {m_bank[3], m_bank[2], m_bank[1], m_bank[0]};
    endtask

    // One clock: sample DUT at negedge, update counter model after the edge.
    task automatic tick();
        logic [3:0] st;
        logic [2:0] bk;
        logic [3:0] dn;
        @(negedge clk);
        st      = cnt_start;
        bk      = cnt_bank;
        dn      = cnt_done;
        hs_seen = req_valid & req_ready;
        if ((st & (st - 4'd1)) != 4'd0) dbl_start++;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (dn[i]) m_asg[i] = 1'b0;
            if (st[i]) begin
                if (m_asg[i] || m_pend[i]) dbl_start++;
                m_pend[i] = 1'b1;
                m_wait[i] = asg_dly;
                m_bank[i] = bk;
            end
            if (m_pend[i]) begin
                if (m_wait[i] == 0) begin
                    m_asg[i]  = 1'b1;
                    m_pend[i] = 1'b0;
                end else begin
                    m_wait[i] = m_wait[i] - 1;
                end
            end
        end
        cnt_done  = done_next;
        done_next = '0;
        drive_model();
        #1;
    endtask

    task automatic req(input logic [2:0] b);
        req_valid = 1'b1;
        req_bank  = b;
        hs_seen   = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (hs_seen) break;
        end
        if (!hs_seen) begin
            n_chk++;
            n_err++;
            $display("FAIL req_timeout: bank %0d not accepted within 50 cycles", b);
        end
        req_valid = 1'b0;
    endtask

    task automatic fin(input logic [3:0] mask);
        done_next = mask;
        tick();
    endtask

    task automatic model_clear();
        m_asg     = '0;
        m_pend    = '0;
        done_next = '0;
        cnt_done  = '0;
        req_valid = 1'b0;
        drive_model();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_bank  = 3'd0;
        trfc_pb   = 8'h2A;
        asg_dly   = 0;
        dbl_start = 0;
        hs_seen   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_bank[i] = 3'd0;
            m_wait[i] = 0;
        end
        model_clear();

        //              rv    rb    fin    rdy   start    cbank busy   rdone
        tbl[0]  = '{1'b1, 3'd3, 4'h0, 1'b0, 4'b0001, 3'd3, 8'h00, 8'h00};
        tbl[1]  = '{1'b0, 3'd3, 4'h0, 1'b1, 4'b0000, 3'd3, 8'h08, 8'h00};
        tbl[2]  = '{1'b0, 3'd3, 4'h1, 1'b1, 4'b0000, 3'd3, 8'h08, 8'h00};
        tbl[3]  = '{1'b0, 3'd3, 4'h0, 1'b1, 4'b0000, 3'd3, 8'h00, 8'h08};
        tbl[4]  = '{1'b0, 3'd3, 4'h0, 1'b1, 4'b0000, 3'd3, 8'h00, 8'h00};
        tbl[5]  = '{1'b1, 3'd2, 4'h0, 1'b0, 4'b0001, 3'd2, 8'h00, 8'h00};
        tbl[6]  = '{1'b1, 3'd2, 4'h0, 1'b1, 4'b0000, 3'd2, 8'h04, 8'h00};
        tbl[7]  = '{1'b1, 3'd2, 4'h0, 1'b0, 4'b0000, 3'd2, 8'h04, 8'h00};
        tbl[8]  = '{1'b0, 3'd2, 4'h1, 1'b0, 4'b0000, 3'd2, 8'h04, 8'h00};
        tbl[9]  = '{1'b0, 3'd2, 4'h0, 1'b0, 4'b0001, 3'd2, 8'h00, 8'h04};
        tbl[10] = '{1'b0, 3'd2, 4'h0, 1'b1, 4'b0000, 3'd2, 8'h04, 8'h00};
        tbl[11] = '{1'b0, 3'd2, 4'h1, 1'b1, 4'b0000, 3'd2, 8'h04, 8'h00};
        tbl[12] = '{1'b0, 3'd2, 4'h0, 1'b1, 4'b0000, 3'd2, 8'h00, 8'h04};
        tbl[13] = '{1'b0, 3'd2, 4'h0, 1'b1, 4'b0000, 3'd2, 8'h00, 8'h00};

        // reset state
        #12;
        chk("rst_ready", req_ready, 1);
        chk("rst_start", cnt_start, 0);
        chk("rst_busy", bank_busy, 0);
        chk("rst_rdone", refresh_done, 0);
        chk("rst_err", err, 0);
        chk("rst_cbank", cnt_bank, 0);
        chk("trfc_fwd", cnt_trfc_pb, 8'h2A);
        #10 rst_n = 1'b1;
        tick();

        // single refresh to bank 3, then bank 2 twice with the second blocked on busy
        for (int r = 0; r < 14; r++) begin
            req_valid = tbl[r].rv;
            req_bank  = tbl[r].rb;
            done_next = tbl[r].fin;
            tick();
            chk($sformatf("v%0d_ready", r), req_ready, tbl[r].x_ready);
            chk($sformatf("v%0d_start", r), cnt_start, tbl[r].x_start);
            chk($sformatf("v%0d_cbank", r), cnt_bank, tbl[r].x_cbank);
            chk($sformatf("v%0d_busy", r), bank_busy, tbl[r].x_busy);
            chk($sformatf("v%0d_rdone", r), refresh_done, tbl[r].x_rdone);
            chk($sformatf("v%0d_err", r), err, 0);
        end
        req_valid = 1'b0;

        trfc_pb = 8'h00;
        #1;
        chk("trfc_zero_fwd", cnt_trfc_pb, 8'h00);

        // all four counters busy, fifth request waits for the first finisher
        req(3'd0);
        req(3'd1);
        req(3'd2);
        req(3'd3);
        chk("fill_start3", cnt_start, 4'b1000);
        req(3'd4);
        chk("full_start", cnt_start, 4'b0000);
        chk("full_ready", req_ready, 0);
        chk("full_busy", bank_busy, 8'h0F);
        tick();
        tick();
        chk("full_hold_start", cnt_start, 4'b0000);
        chk("full_hold_ready", req_ready, 0);
        fin(4'b0010);
        chk("done_cycle_start", cnt_start, 4'b0000);
        tick();
        chk("reuse_start", cnt_start, 4'b0010);
        chk("reuse_cbank", cnt_bank, 3'd4);
        chk("reuse_busy", bank_busy, 8'h0D);
        chk("reuse_rdone", refresh_done, 8'h02);
        tick();
        chk("reuse_busy2", bank_busy, 8'h1D);
        chk("reuse_ready", req_ready, 1);
        fin(4'b1111);
        tick();
        chk("drain_rdone", refresh_done, 8'h1D);
        chk("drain_busy", bank_busy, 8'h00);
        tick();

        // two counters finishing together
        req(3'd0);
        req(3'd1);
        tick();
        chk("dual_busy", bank_busy, 8'h03);
        fin(4'b0011);
        chk("dual_busy_hold", bank_busy, 8'h03);
        tick();
        chk("dual_busy_clr", bank_busy, 8'h00);
        chk("dual_rdone", refresh_done, 8'h03);
        tick();
        chk("dual_rdone_clr", refresh_done, 8'h00);
        chk("dual_err", err, 0);

        // late assigned with back-to-back requests
        for (int d = 1; d <= 2; d++) begin
            asg_dly = d;
            req(3'd5);
            req(3'd6);
            req(3'd7);
            for (int k = 0; k < 4; k++) tick();
            chk($sformatf("late%0d_asg_map", d), m_asg, 4'b0111);
            chk($sformatf("late%0d_busy", d), bank_busy, 8'hE0);
            chk($sformatf("late%0d_dbl", d), dbl_start, 0);
            chk($sformatf("late%0d_err", d), err, 0);
            fin(4'b0111);
            tick();
            chk($sformatf("late%0d_rdone", d), refresh_done, 8'hE0);
            tick();
        end
        asg_dly = 0;

        // two done pulses naming the same bank
        req(3'd1);
        tick();
        m_bank[1] = 3'd1;
        fin(4'b0011);
        tick();
        chk("dup_err", err, 1);
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        chk("dup_rst_err", err, 0);
        #3 rst_n = 1'b1;
        tick();

        // done for an idle bank, sticky error, reset mid-PEND
        m_bank[3] = 3'd6;
        fin(4'b1000);
        tick();
        chk("idle_done_err", err, 1);
        tick();
        tick();
        chk("idle_done_sticky", err, 1);
        req(3'd2);
        tick();
        chk("pend_setup_busy", bank_busy, 8'h04);
        req(3'd2);
        chk("pend_ready", req_ready, 0);
        chk("pend_start", cnt_start, 4'b0000);
        chk("pend_err_still", err, 1);
        #2 rst_n = 1'b0;
        model_clear();
        #1;
        chk("midrst_ready", req_ready, 1);
        chk("midrst_busy", bank_busy, 8'h00);
        chk("midrst_err", err, 0);
        chk("midrst_start", cnt_start, 4'b0000);
        #3 rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_start", cnt_start, 4'b0000);
        chk("post_rst_busy", bank_busy, 8'h00);
        chk("post_rst_dbl", dbl_start, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
